// File: rtl/knips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : knips_pkg
//  Description : Shared types, defaults and helpers for the KNIPS fetch
//                sequencer (fetch FSM state encoding, default widths, the
//                halt-word default and the branch-target helper).
//  Contents    : fetch_state_t  - fetch FSM states {IDLE, RUN, DRAIN, DONE}
//                DEF_A/W/CNT_W  - default PC, instruction and counter widths
//                HALT_WORD_DEF  - default halt encoding (all ones)
//                next_pc()      - absolute / PC-relative redirect target
//  Revision    : 1.0 - initial release
// ============================================================================
package knips_pkg;

  // Fetch sequencer states. Explicit 2-bit encoding keeps the register
  // width fixed independent of tool enum sizing.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int DEF_A     = 10;
  localparam int DEF_W     = 9;
  localparam int DEF_CNT_W = 16;

  localparam logic [DEF_W-1:0] HALT_WORD_DEF = '1;

  // Width used by next_pc(). Callers zero-extend into this width and keep
  // the low A bits of the result; because the low bits of a sum depend only
  // on the low bits of the operands, truncation yields exact modulo-2^A
  // arithmetic for any A up to PC_MAX_W.
  localparam int PC_MAX_W = 32;

  // Redirect target: absolute (abs=1) or PC-relative two's-complement
  // offset (abs=0).
  function automatic logic [PC_MAX_W-1:0] next_pc(
    input logic [PC_MAX_W-1:0] pc,
    input logic                abs,
    input logic [PC_MAX_W-1:0] tgt
  );
    next_pc = abs ? tgt : (pc + tgt);
  endfunction

endpackage : knips_pkg
`default_nettype wire

// File: rtl/knips_pc.sv
`default_nettype none
// ============================================================================
//  Module      : knips_pc
//  Description : Program-counter register for the KNIPS fetch sequencer.
//                Supports load, absolute/relative branch, increment and
//                hold (when no control is asserted). All arithmetic wraps
//                modulo 2^A.
//  Ports       : clk        in  1  rising-edge clock
//                rst_n      in  1  asynchronous active-low reset (PC -> 0)
//                load       in  1  PC <= load_addr (highest priority)
//                load_addr  in  A  value for load
//                branch     in  1  PC <= redirect target
//                branch_abs in  1  1: absolute target, 0: PC-relative offset
//                target     in  A  branch target / offset
//                incr       in  1  PC <= PC + 1 (lowest priority)
//                pc         out A  current program counter (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module knips_pc
  import knips_pkg::*;
#(
  parameter int A = DEF_A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [A-1:0] load_addr,
  input  logic         branch,
  input  logic         branch_abs,
  input  logic [A-1:0] target,
  input  logic         incr,
  output logic [A-1:0] pc
);

  localparam logic [A-1:0] C_PC_ONE = {{(A-1){1'b0}}, 1'b1};

  logic [A-1:0]          r_pc;
  logic [PC_MAX_W-1:0]   w_redirect_full;
  logic [A-1:0]          w_redirect;
  logic [PC_MAX_W-A-1:0] w_unused_redirect_hi;

  assign w_redirect_full      = next_pc(PC_MAX_W'(r_pc), branch_abs, PC_MAX_W'(target));
  assign w_redirect           = w_redirect_full[A-1:0];
  // Upper bits are discarded on purpose: that truncation is the modulo wrap.
  assign w_unused_redirect_hi = w_redirect_full[PC_MAX_W-1:A];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= load_addr;
    end else if (branch) begin
      r_pc <= w_redirect;
    end else if (incr) begin
      r_pc <= r_pc + C_PC_ONE;
    end
  end

  assign pc = r_pc;

endmodule : knips_pc
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_ctrl
//  Description : KNIPS fetch sequencer. Owns the PC (via knips_pc), drives
//                the external combinational ROM address, registers each
//                fetched word into the IR, handles one-bubble branch
//                redirects, detects the halt word and provides a Start/Done
//                handshake plus a saturating retired-instruction counter.
//  Ports       : Clk          in  1      rising-edge clock
//                Reset_n      in  1      asynchronous active-low reset
//                Start        in  1      start pulse (IDLE/DONE only)
//                StartAddr    in  A      initial PC for the run
//                Stall        in  1      hold PC and IR this cycle
//                BranchTaken  in  1      redirect fetch (qualifies Target)
//                BranchAbs    in  1      1: absolute, 0: PC-relative
//                Target       in  A      branch target / offset
//                InstAddress  out A      ROM address (= PC, registered)
//                InstIn       in  W      ROM data for InstAddress
//                Inst         out W      instruction register
//                InstValid    out 1      IR holds a live instruction
//                Busy         out 1      state == RUN
//                Done         out 1      state == DONE
//                InstCount    out CNT_W  instructions retired (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
  import knips_pkg::*;
#(
  parameter int             A         = DEF_A,
  parameter int             W         = DEF_W,
  parameter logic [W-1:0]   HALT_WORD = {W{1'b1}},
  parameter int             CNT_W     = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [A-1:0]     StartAddr,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic             BranchAbs,
  input  logic [A-1:0]     Target,
  output logic [A-1:0]     InstAddress,
  input  logic [W-1:0]     InstIn,
  output logic [W-1:0]     Inst,
  output logic             InstValid,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_t r_state;

  logic             w_start;
  logic             w_run_go;
  logic             w_is_halt;
  logic             w_branch;
  logic             w_incr;
  logic [CNT_W-1:0] w_count_next;

  // Start is honoured only while no program is in flight.
  assign w_start   = Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run_go  = (r_state == RUN) && !Stall;
  assign w_is_halt = (InstIn == HALT_WORD);
  // A stalled branch is dropped; execute re-presents it once the stall clears.
  assign w_branch  = w_run_go && BranchTaken;
  // On a halt fetch the PC parks on the halt address instead of advancing.
  assign w_incr    = w_run_go && !BranchTaken && !w_is_halt;

  assign w_count_next = (&InstCount) ? InstCount : (InstCount + C_CNT_ONE);

  knips_pc #(
    .A (A)
  ) u_pc (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .load       (w_start),
    .load_addr  (StartAddr),
    .branch     (w_branch),
    .branch_abs (BranchAbs),
    .target     (Target),
    .incr       (w_incr),
    .pc         (InstAddress)
  );

  // FSM with registered IR, valid, status and retire counter. The IR word is
  // retired on any non-stalled cycle in which it is valid, whether the next
  // slot is a fetch or a branch bubble.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      Inst      <= '0;
      InstValid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      InstCount <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (Start) begin
            r_state   <= RUN;
            Busy      <= 1'b1;
            Done      <= 1'b0;
            InstValid <= 1'b0;
            InstCount <= '0;
          end
        end

        RUN: begin
          if (!Stall) begin
            if (InstValid) begin
              InstCount <= w_count_next;
            end
            if (BranchTaken) begin
              // Bubble: the word at InstAddress (even a halt) is squashed.
              InstValid <= 1'b0;
            end else begin
              Inst      <= InstIn;
              InstValid <= 1'b1;
              if (w_is_halt) begin
                r_state <= DRAIN;
                Busy    <= 1'b0;
              end
            end
          end
        end

        DRAIN: begin
          // The halt word sits in the IR until a non-stalled cycle retires it.
          if (!Stall) begin
            InstCount <= w_count_next;
            InstValid <= 1'b0;
            r_state   <= DONE;
            Done      <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : inst_fetch_ctrl
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_ctrl
//  Description : Directed self-checking bench for inst_fetch_ctrl with a
//                behavioural combinational ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  localparam int A     = 10;
  localparam int W     = 9;
  localparam int CNT_W = 16;

  logic             Clk;
  logic             Reset_n;
  logic             Start;
  logic [A-1:0]     StartAddr;
  logic             Stall;
  logic             BranchTaken;
  logic             BranchAbs;
  logic [A-1:0]     Target;
  logic [A-1:0]     InstAddress;
  logic [W-1:0]     InstIn;
  logic [W-1:0]     Inst;
  logic             InstValid;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] InstCount;

  logic [W-1:0] rom [0:(1<<A)-1];

  int checks = 0;
  int errors = 0;

  inst_fetch_ctrl #(
    .A         (A),
    .W         (W),
    .HALT_WORD ({W{1'b1}}),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchAbs   (BranchAbs),
    .Target      (Target),
    .InstAddress (InstAddress),
    .InstIn      (InstIn),
    .Inst        (Inst),
    .InstValid   (InstValid),
    .Busy        (Busy),
    .Done        (Done),
    .InstCount   (InstCount)
  );

  assign InstIn = rom[InstAddress];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    chk("done_within_bound", 32'(Done), 32'd1);
  endtask

  task automatic start_run(input logic [A-1:0] addr);
    Start     = 1'b1;
    StartAddr = addr;
    tick();
    Start     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << A); i++) rom[i] = '0;
    Reset_n = 1'b0; Start = 0; StartAddr = '0; Stall = 0;
    BranchTaken = 0; BranchAbs = 0; Target = '0;

    // Reset state
    tick(); tick();
    chk("rst_addr",  32'(InstAddress), 32'd0);
    chk("rst_inst",  32'(Inst),        32'd0);
    chk("rst_valid", 32'(InstValid),   32'd0);
    chk("rst_busy",  32'(Busy),        32'd0);
    chk("rst_done",  32'(Done),        32'd0);
    chk("rst_count", 32'(InstCount),   32'd0);
    Reset_n = 1'b1;
    tick();

    // 1: basic sequential run to halt
    rom[0] = 9'h001; rom[1] = 9'h049; rom[2] = 9'h1FF;
    start_run(10'd0);
    chk("t1_busy",   32'(Busy),        32'd1);
    chk("t1_addr0",  32'(InstAddress), 32'd0);
    chk("t1_valid0", 32'(InstValid),   32'd0);
    tick();
    chk("t1_inst1",  32'(Inst),        32'h001);
    chk("t1_valid1", 32'(InstValid),   32'd1);
    tick();
    chk("t1_inst2",  32'(Inst),        32'h049);
    chk("t1_cnt2",   32'(InstCount),   32'd1);
    tick();
    chk("t1_inst3",  32'(Inst),        32'h1FF);
    chk("t1_done3",  32'(Done),        32'd0);
    chk("t1_busy3",  32'(Busy),        32'd0);
    tick();
    chk("t1_done4",  32'(Done),        32'd1);
    chk("t1_cnt4",   32'(InstCount),   32'd3);
    chk("t1_pc4",    32'(InstAddress), 32'd2);
    chk("t1_valid4", 32'(InstValid),   32'd0);
    tick();
    chk("t1_hold_inst", 32'(Inst),      32'h1FF);
    chk("t1_hold_cnt",  32'(InstCount), 32'd3);

    // 2: stall freezes IR, PC and counter
    start_run(10'd0);
    chk("t2_done_clr", 32'(Done),      32'd0);
    chk("t2_cnt_clr",  32'(InstCount), 32'd0);
    tick(); tick();
    chk("t2_inst", 32'(Inst), 32'h049);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_stall_inst", 32'(Inst),        32'h049);
      chk("t2_stall_addr", 32'(InstAddress), 32'd2);
      chk("t2_stall_cnt",  32'(InstCount),   32'd1);
    end
    Stall = 1'b0;
    tick();
    chk("t2_resume_inst", 32'(Inst),      32'h1FF);
    chk("t2_resume_cnt",  32'(InstCount), 32'd2);
    wait_done();
    chk("t2_cnt_final", 32'(InstCount), 32'd3);

    // 3: absolute branch squashes a halt word at address 4
    rom[1] = 9'h011; rom[2] = 9'h1FF; rom[3] = 9'h0A3; rom[4] = 9'h1FF;
    start_run(10'd3);
    chk("t3_addr", 32'(InstAddress), 32'd3);
    tick();
    chk("t3_inst", 32'(Inst),        32'h0A3);
    chk("t3_addr4", 32'(InstAddress), 32'd4);
    BranchTaken = 1'b1; BranchAbs = 1'b1; Target = 10'd1;
    tick();
    BranchTaken = 1'b0;
    chk("t3_bubble", 32'(InstValid),   32'd0);
    chk("t3_redir",  32'(InstAddress), 32'd1);
    chk("t3_nodone", 32'(Done),        32'd0);
    chk("t3_busy",   32'(Busy),        32'd1);
    chk("t3_cnt",    32'(InstCount),   32'd1);
    tick();
    chk("t3_inst_after", 32'(Inst),      32'h011);
    chk("t3_cnt_bubble", 32'(InstCount), 32'd1);
    wait_done();
    chk("t3_cnt_final", 32'(InstCount), 32'd3);

    // 4a: relative branch PC=2, offset -2 -> 0
    rom[0] = 9'h001;
    start_run(10'd1);
    tick();
    chk("t4_inst", 32'(Inst),        32'h011);
    chk("t4_pc2",  32'(InstAddress), 32'd2);
    BranchTaken = 1'b1; BranchAbs = 1'b0; Target = 10'h3FE;
    tick();
    BranchTaken = 1'b0;
    chk("t4_rel_addr",  32'(InstAddress), 32'd0);
    chk("t4_rel_valid", 32'(InstValid),   32'd0);
    wait_done();
    chk("t4_rel_cnt", 32'(InstCount), 32'd4);

    // 4b: sequential wrap from 1023 to 0
    rom[1023] = 9'h055;
    start_run(10'd1023);
    chk("t4_wrap_start", 32'(InstAddress), 32'd1023);
    tick();
    chk("t4_wrap_inst", 32'(Inst),        32'h055);
    chk("t4_wrap_addr", 32'(InstAddress), 32'd0);
    wait_done();
    chk("t4_wrap_cnt", 32'(InstCount), 32'd4);

    // 5: stall+branch ignored; Start ignored during RUN
    start_run(10'd0);
    tick();
    chk("t5_inst", 32'(Inst), 32'h001);
    Stall = 1'b1; BranchTaken = 1'b1; BranchAbs = 1'b1; Target = 10'd7;
    tick();
    chk("t5_hold_addr",  32'(InstAddress), 32'd1);
    chk("t5_hold_inst",  32'(Inst),        32'h001);
    chk("t5_hold_valid", 32'(InstValid),   32'd1);
    chk("t5_hold_cnt",   32'(InstCount),   32'd0);
    Stall = 1'b0; BranchTaken = 1'b0;
    Start = 1'b1; StartAddr = 10'd500;
    tick();
    Start = 1'b0;
    chk("t5_nostart_addr", 32'(InstAddress), 32'd2);
    chk("t5_nostart_inst", 32'(Inst),        32'h011);
    chk("t5_nostart_cnt",  32'(InstCount),   32'd1);
    wait_done();
    chk("t5_cnt_final", 32'(InstCount), 32'd3);

    // 6: asynchronous reset mid-run, then restart
    start_run(10'd0);
    tick();
    chk("t6_pre_inst", 32'(Inst), 32'h001);
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_rst_addr",  32'(InstAddress), 32'd0);
    chk("t6_rst_inst",  32'(Inst),        32'd0);
    chk("t6_rst_valid", 32'(InstValid),   32'd0);
    chk("t6_rst_busy",  32'(Busy),        32'd0);
    chk("t6_rst_done",  32'(Done),        32'd0);
    chk("t6_rst_cnt",   32'(InstCount),   32'd0);
    #2 Reset_n = 1'b1;
    tick();
    chk("t6_idle_busy", 32'(Busy), 32'd0);
    start_run(10'd1);
    chk("t6_restart_addr", 32'(InstAddress), 32'd1);
    chk("t6_restart_busy", 32'(Busy),        32'd1);
    tick();
    chk("t6_restart_inst", 32'(Inst), 32'h011);
    wait_done();
    chk("t6_cnt_final", 32'(InstCount), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_inst_fetch_ctrl
`default_nettype wire
